// File: rtl/seq_cla_adder16.sv
// ============================================================================
// Module   : seq_cla_adder16 (+ seq_cla_slice4)
// Function : Sequential adder; one 4-bit carry-lookahead slice reused per nibble
// Revision : 1.0
// ============================================================================
`default_nettype none

module seq_cla_slice4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c,
  output logic [3:0] sum,
  output logic       c4
);
  logic [3:0] p;
  logic [3:0] g;
  logic       c1;
  logic       c2;
  logic       c3;

  assign p = a ^ b;
  assign g = a & b;

  // Every carry is a flat sum of products on P, G and c.
  assign c1 = g[0] | (p[0] & c);
  assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
  assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c);
  assign c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
            | (p[3] & p[2] & p[1] & p[0] & c);

  assign sum = p ^ {c3, c2, c1, c};
endmodule

module seq_cla_adder16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);
  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam int MSB = WIDTH - 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CW-1:0] CNT_LAST = CW'(NIB - 1);

  generate
    if ((WIDTH < 4) || ((WIDTH % 4) != 0)) begin : g_width_check
      $error("seq_cla_adder16: WIDTH must be a multiple of 4 and at least 4");
    end
  endgenerate

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [3:0]       a_nib;
  logic [3:0]       b_nib;
  logic [3:0]       s_nib;
  logic             c4;

  // Constant-index selection keeps the nibble mux free of out-of-range slices.
  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int i = 0; i < NIB; i++) begin
      if (cnt_q == CW'(i)) begin
        a_nib = a_q[4*i +: 4];
        b_nib = b_q[4*i +: 4];
      end
    end
  end

  seq_cla_slice4 u_slice (
    .a   (a_nib),
    .b   (b_nib),
    .c   (carry_q),
    .sum (s_nib),
    .c4  (c4)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          sum_d   = '0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        for (int i = 0; i < NIB; i++) begin
          if (cnt_q == CW'(i)) begin
            sum_d[4*i +: 4] = s_nib;
          end
        end
        carry_d = c4;
        if (cnt_q == CNT_LAST) begin
          // The top nibble is being written now, so its MSB is s_nib[3].
          cout_d  = c4;
          ovf_d   = (a_q[MSB] == b_q[MSB]) && (s_nib[3] != a_q[MSB]);
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_RUN);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
endmodule

`default_nettype wire

// File: tb/tb_seq_cla_adder16.sv
// ============================================================================
// Module   : tb_seq_cla_adder16
// Function : Scoreboard bench for seq_cla_adder16 at WIDTH 16, 4 and 32
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_seq_cla_adder16;
  typedef struct {
    int          w;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] a_bus = '0;
  logic [31:0] b_bus = '0;
  logic        cin = 1'b0;
  int          sel_w = 16;

  int total = 0;
  int bad = 0;
  exp_t exp_q[$];

  logic        iv4, iv16, iv32, or4, or16, or32;
  logic        rdy4, rdy16, rdy32, val4, val16, val32, busy4, busy16, busy32;
  logic        co4, co16, co32, ov4, ov16, ov32;
  logic [3:0]  s4;
  logic [15:0] s16;
  logic [31:0] s32;

  logic [31:0] obs_sum;
  logic        obs_cout, obs_ovf, obs_valid, obs_ready, obs_busy;

  always #5 clk = ~clk;

  assign iv4  = in_valid & (sel_w == 4);
  assign iv16 = in_valid & (sel_w == 16);
  assign iv32 = in_valid & (sel_w == 32);
  assign or4  = out_ready & (sel_w == 4);
  assign or16 = out_ready & (sel_w == 16);
  assign or32 = out_ready & (sel_w == 32);

  seq_cla_adder16 #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(rdy4), .a(a_bus[3:0]), .b(b_bus[3:0]),
    .cin(cin), .out_valid(val4), .out_ready(or4), .sum(s4), .cout(co4), .ovf(ov4), .busy(busy4));

  seq_cla_adder16 dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(rdy16), .a(a_bus[15:0]), .b(b_bus[15:0]),
    .cin(cin), .out_valid(val16), .out_ready(or16), .sum(s16), .cout(co16), .ovf(ov16), .busy(busy16));

  seq_cla_adder16 #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(rdy32), .a(a_bus), .b(b_bus),
    .cin(cin), .out_valid(val32), .out_ready(or32), .sum(s32), .cout(co32), .ovf(ov32), .busy(busy32));

  always_comb begin
    case (sel_w)
      4: begin
        obs_sum = {28'b0, s4}; obs_cout = co4; obs_ovf = ov4;
        obs_valid = val4; obs_ready = rdy4; obs_busy = busy4;
      end
      32: begin
        obs_sum = s32; obs_cout = co32; obs_ovf = ov32;
        obs_valid = val32; obs_ready = rdy32; obs_busy = busy32;
      end
      default: begin
        obs_sum = {16'b0, s16}; obs_cout = co16; obs_ovf = ov16;
        obs_valid = val16; obs_ready = rdy16; obs_busy = busy16;
      end
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s w=%0d got=%h exp=%h t=%0t", tag, sel_w, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                 input logic c);
    exp_t        r;
    logic [31:0] m;
    logic [32:0] full;
    m      = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    full   = {1'b0, a & m} + {1'b0, b & m} + {32'b0, c};
    r.w    = w;
    r.sum  = full[31:0] & m;
    r.cout = full[w];
    r.ovf  = (a[w-1] == b[w-1]) && (r.sum[w-1] != a[w-1]);
    return r;
  endfunction

  // One complete transaction; noise scrambles operands and pulses in_valid after acceptance.
  task automatic run_op(input int w, input logic [31:0] a, input logic [31:0] b, input logic c,
                        input int delay, input bit noise);
    int          cyc;
    exp_t        e;
    logic [31:0] hs;
    logic        hc, ho;
    sel_w = w;
    @(negedge clk);
    chk("idle_ready", {31'b0, obs_ready}, 32'd1);
    a_bus = a; b_bus = b; cin = c; in_valid = 1'b1;
    @(posedge clk);
    exp_q.push_back(model(w, a, b, c));
    @(negedge clk);
    in_valid = 1'b0;
    if (noise) begin
      a_bus = $urandom; b_bus = $urandom; cin = $urandom_range(0, 1); in_valid = 1'b1;
    end
    cyc = 0;
    while (!obs_valid && cyc < 40) begin
      chk("run_busy", {31'b0, obs_busy}, 32'd1);
      if (noise) chk("run_not_ready", {31'b0, obs_ready}, 32'd0);
      @(negedge clk);
      cyc++;
    end
    chk("latency", cyc, w / 4);
    if (exp_q.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk("sum", obs_sum, e.sum);
      chk("cout", {31'b0, obs_cout}, {31'b0, e.cout});
      chk("ovf", {31'b0, obs_ovf}, {31'b0, e.ovf});
    end
    hs = obs_sum; hc = obs_cout; ho = obs_ovf;
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      chk("hold_valid", {31'b0, obs_valid}, 32'd1);
      chk("hold_sum", obs_sum, hs);
      chk("hold_flags", {30'b0, obs_cout, obs_ovf}, {30'b0, hc, ho});
      if (noise) chk("done_not_ready", {31'b0, obs_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("release_valid", {31'b0, obs_valid}, 32'd0);
    chk("release_idle", {30'b0, obs_ready, obs_busy}, 32'd2);
    chk("idle_keeps_sum", obs_sum, hs);
    in_valid = 1'b0;
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    #3;
    chk("rst_sum", obs_sum, 32'd0);
    chk("rst_flags", {28'b0, obs_cout, obs_ovf, obs_valid, obs_busy}, 32'd0);
    chk("rst_ready", {31'b0, obs_ready}, 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_op(16, 32'hFFFF, 32'h0001, 1'b0, 0, 1'b0);
    run_op(16, 32'h7FFF, 32'h0001, 1'b0, 1, 1'b0);
    run_op(16, 32'h1234, 32'h4321, 1'b1, 2, 1'b1);
    run_op(16, 32'h0000, 32'h0000, 1'b0, 10, 1'b1);
    run_op(16, 32'h8000, 32'h8000, 1'b0, 0, 1'b0);

    // Reset mid-operation: previous result left cout=ovf=1.
    sel_w = 16;
    @(negedge clk);
    a_bus = 32'hFFFF; b_bus = 32'hFFFF; cin = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_sum", obs_sum, 32'd0);
    chk("arst_flags", {28'b0, obs_cout, obs_ovf, obs_valid, obs_busy}, 32'd0);
    chk("arst_ready", {31'b0, obs_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("arst_no_result", {30'b0, obs_valid, obs_busy}, 32'd0);
    run_op(16, 32'h0001, 32'h0001, 1'b0, 0, 1'b0);

    for (int n = 0; n < 1000; n++)
      run_op(16, $urandom, $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 5),
             ($urandom_range(0, 3) == 0));

    run_op(4, 32'hF, 32'h1, 1'b0, 0, 1'b0);
    run_op(4, 32'h7, 32'h1, 1'b0, 2, 1'b1);
    for (int n = 0; n < 100; n++)
      run_op(4, $urandom, $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 5), 1'b0);

    run_op(32, 32'hFFFF_FFFF, 32'h1, 1'b0, 0, 1'b0);
    run_op(32, 32'h7FFF_FFFF, 32'h0, 1'b1, 3, 1'b1);
    for (int n = 0; n < 100; n++)
      run_op(32, $urandom, $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 5), 1'b0);

    chk("sb_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/seq_cla_adder16.md
SEQ_CLA_ADDER16 -- requirements
Module: seq_cla_adder16

Interface
REQ-001 Parameter: WIDTH, 16, operand width in bits; the value SHALL be a multiple of 4 and at least 4.
REQ-002 Port: clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: in_valid  input  1  the requester presents an operand set.
REQ-005 Port: in_ready  output  1  the block can accept an operand set.
REQ-006 Port: a  input  WIDTH  operand A.
REQ-007 Port: b  input  WIDTH  operand B.
REQ-008 Port: cin  input  1  carry-in.
REQ-009 Port: out_valid  output  1  the result is held and valid.
REQ-010 Port: out_ready  input  1  the consumer accepts the result.
REQ-011 Port: sum  output  WIDTH  a+b+cin, modulo 2^WIDTH.
REQ-012 Port: cout  output  1  carry-out of bit WIDTH-1.
REQ-013 Port: ovf  output  1  two's-complement overflow of the addition.
REQ-014 Port: busy  output  1  high while the state is RUN.

Function
REQ-015 Datapath: a single 4-bit carry-lookahead slice SHALL be reused once per nibble.
- P = a_n XOR b_n and G = a_n AND b_n.
- C1..C4 SHALL come from the full two-level lookahead equations on P, G and the carry register; no ripple is allowed inside the slice.
- sum_n = P XOR {C3,C2,C1,c}.
REQ-016 The FSM SHALL have three states (IDLE, RUN, DONE) and a nibble counter of clog2(WIDTH/4) bits, minimum 1 bit.
REQ-017 in_ready SHALL equal (state==IDLE); out_valid SHALL equal (state==DONE).
REQ-018 IDLE with in_valid high at a clock edge: latch a, b and cin; clear the sum register; set cnt=0; enter RUN.
REQ-019 RUN, each edge:
- Process nibble cnt.
- Write sum[4*cnt+3:4*cnt].
- Load the carry register with C4.
- Increment cnt.
REQ-020 RUN, edge where cnt==WIDTH/4-1, in addition to REQ-019:
- Set cout=C4.
- Set ovf=(a[MSB]==b[MSB]) AND (sum[MSB]!=a[MSB]).
- Enter DONE.
- cnt SHALL wrap to 0.
REQ-021 Latency: out_valid SHALL rise exactly WIDTH/4 clock edges after the accepting edge (4 edges for WIDTH=16).
REQ-022 DONE:
- sum, cout and ovf SHALL hold stable until an edge with out_ready high.
- That edge SHALL return the block to IDLE.
- Outputs keep their last values in IDLE.
REQ-023 in_valid asserted in RUN or DONE SHALL be ignored. The latched operands SHALL NOT change, and no request SHALL be queued.
REQ-024 Changes on a, b or cin after acceptance SHALL NOT affect the result.
REQ-025 out_ready asserted outside DONE SHALL have no effect.
REQ-026 Back-to-back: a DONE→IDLE edge SHALL NOT accept new operands. The minimum issue interval is WIDTH/4+2 cycles when out_ready is held high.
REQ-027 There are no combinational paths from in_valid or out_ready to any output.

Reset
REQ-028 rst high SHALL immediately, without waiting for clk, force:
- state=IDLE, cnt=0, carry register=0, operand registers=0;
- sum=0, cout=0, ovf=0;
- out_valid=0, busy=0, in_ready=1.
REQ-029 Reset asserted in RUN or DONE SHALL discard the operation and produce no result.
REQ-030 After rst deasserts, the first rising edge with in_valid high SHALL be accepted normally.

Verification
REQ-031 Carry through all nibbles: a=16'hFFFF, b=16'h0001, cin=0 -> 4 edges later out_valid=1, sum=16'h0000, cout=1, ovf=0.
REQ-032 Signed overflow: a=16'h7FFF, b=16'h0001, cin=0 -> sum=16'h8000, cout=0, ovf=1. Also a=16'h8000, b=16'h8000 -> sum=0, cout=1, ovf=1.
REQ-033 Carry-in: a=16'h1234, b=16'h4321, cin=1 -> sum=16'h5556, cout=0, ovf=0. Changing a and b to 0 during RUN leaves this result unchanged.
REQ-034 Backpressure:
- Hold out_ready=0 for 10 cycles in DONE -> sum, cout and ovf remain stable and out_valid stays 1.
- in_valid pulses during RUN and DONE are ignored (in_ready=0).
- out_ready=1 -> IDLE on the next edge.
REQ-035 Async reset: assert rst between clock edges in the second RUN cycle -> all outputs reach their reset values before the next edge. A new request a=16'h0001, b=16'h0001 then yields sum=16'h0002.
REQ-036 Random: at least 1000 random a, b and cin sets, with random out_ready delays 0-5, checked against a+b+cin. Also run WIDTH=4 (1-cycle latency) and WIDTH=32 (8-cycle latency).
